lc3_int_ctrl: RTL and testbench
===============================

Name: lc3_int_ctrl

Overview:
Parametrised interrupt controller feeding the LC-3 core's interrupt entry. It replaces the single fixed-priority device interrupt path with NUM_SRC sources, each with its own priority, enable, trigger mode and vector. It compares the winner against the current PSR priority and presents one stable request (vector + priority) to the control FSM, with an explicit acknowledge handshake.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..16)
PRIO_W, 3, priority field width (LC-3 PSR priority, levels 0..7)
VEC_BASE, 8'h80, INTV of source 0; source i uses VEC_BASE+i, mod 256

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
irq_in  in  NUM_SRC  raw device interrupt lines
edge_mode  in  NUM_SRC  per source: 1 = rising-edge trigger, 0 = level trigger
ie  in  NUM_SRC  per-source interrupt enable
src_prio  in  NUM_SRC*PRIO_W  priority of source i in bits [i*PRIO_W +: PRIO_W]
cpu_priority  in  PRIO_W  current PSR[10:8]
int_ack  in  1  one-cycle pulse from FSM when INTV is taken (LD_Vector state)
int_req  out  1  interrupt request to FSM (the INT input)
int_vector  out  8  INTV for the current request
int_priority  out  PRIO_W  priority to load into PSR on entry
pending  out  NUM_SRC  pending flags (status/debug)

Behaviour:
- Reset (rst high at a clk edge): pending=0, int_req=0, int_vector=0, int_priority=0, state=IDLE. irq_d is loaded with irq_in, so lines already high at reset release do not generate edges.
- Edge detect: irq_d <= irq_in every cycle. Edge source: pending[i] set on irq_in[i] & ~irq_d[i]. Cleared only by an ack of that source. Setting has priority over a same-cycle clear.
- Level source: pending[i] <= irq_in[i] every cycle. Ack does not clear it; the device must drop the line.
- eligible[i] = pending[i] & ie[i] & (src_prio[i] > cpu_priority), unsigned compare.
- Select (combinational): the eligible source with the highest src_prio wins. Ties go to the lowest index.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if any eligible → REQ. On that edge, latch sel=winner, int_vector=VEC_BASE+sel (8-bit wrap), int_priority=src_prio[sel], int_req=1. int_ack in IDLE is ignored.
  - REQ: int_req held at 1. int_vector and int_priority are frozen; a newly arriving higher-priority source does not preempt the latched request.
    - If int_ack: clear pending[sel] if edge_mode[sel], set int_req=0, go to DONE.
    - Else if eligible[sel]==0 (ie dropped, level removed, or cpu_priority raised): withdraw, int_req=0, go to IDLE.
    - Ack takes precedence over withdrawal in the same cycle.
  - DONE: one bubble cycle, int_req=0 → IDLE. This lets the PSR update before the next arbitration.
- Latency: irq_in first sampled high at edge t → pending at t → int_req high after edge t+1. Back-to-back requests are at least 2 cycles apart (DONE + IDLE).
- int_vector and int_priority keep their last values when int_req=0.
- rst in REQ or DONE: immediate return to reset values. A pending edge interrupt is lost.
- mode or prio change while in REQ: only the frozen outputs are unaffected; eligibility is re-evaluated each cycle.

Decomposition:
- Package lc3_int_pkg: state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2), default PRIO_W, default VEC_BASE.
- One sub-module, lc3_int_prio_sel: combinational parametrised max-priority finder. Inputs: eligible vector and packed priorities. Outputs: any, winning index, winning priority. Implemented as a for-loop with lowest-index tie-break.

Test Plan:
- Reset release with irq_in=8'h01, edge_mode=8'h01, ie=8'hFF → no pending, int_req stays 0 for 10 cycles.
- Edge on src 3 (prio 4), cpu_priority=2 → int_req=1 two cycles later, int_vector=8'h83, int_priority=4. Ack pulse → pending[3]=0, int_req=0 next cycle.
- src 1 and src 5 both prio 6, simultaneous edges → vector 8'h81 first. After ack and DONE, vector 8'h85 is requested.
- Level src 2 (prio 3) while in REQ; cpu_priority raised from 0 to 3 → int_req drops next cycle with no ack. pending[2] stays 1.
- Edge on src 0 in the same cycle as int_ack of src 0 → pending[0] remains 1, and src 0 is re-requested after DONE.
- In REQ for src 4 (prio 2), src 6 (prio 7) fires → int_vector stays 8'h84 until ack, then 8'h86 is requested.

Source files
------------

// File: rtl/lc3_int_pkg.sv
// Shared constants for the LC-3 interrupt controller: FSM encoding and
// default parameter values used by the top and its arbiter.
package lc3_int_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int         DEFAULT_PRIO_W   = 3;
    localparam logic [7:0] DEFAULT_VEC_BASE = 8'h80;

endpackage

// File: rtl/lc3_int_prio_sel.sv
// Combinational max-priority finder over an eligibility vector.
// Strict greater-than compare means equal priorities resolve to the lowest index.
module lc3_int_prio_sel #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]        eligible_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    output logic                      any_o,
    output logic [IDX_W-1:0]          idx_o,
    output logic [PRIO_W-1:0]         prio_o
);

    always_comb begin
        any_o  = 1'b0;
        idx_o  = '0;
        prio_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible_i[i] && (!any_o || (prio_i[i*PRIO_W +: PRIO_W] > prio_o))) begin
                any_o  = 1'b1;
                idx_o  = IDX_W'(i);
                prio_o = prio_i[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/lc3_int_ctrl.sv
// Multi-source interrupt controller for the LC-3 core: per-source pending/enable,
// priority arbitration against PSR priority, and a latched request with ack handshake.
module lc3_int_ctrl
    import lc3_int_pkg::*;
#(
    parameter int         NUM_SRC  = 8,
    parameter int         PRIO_W   = DEFAULT_PRIO_W,
    parameter logic [7:0] VEC_BASE = DEFAULT_VEC_BASE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq_in,
    input  logic [NUM_SRC-1:0]        edge_mode,
    input  logic [NUM_SRC-1:0]        ie,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]         cpu_priority,
    input  logic                      int_ack,
    output logic                      int_req,
    output logic [7:0]                int_vector,
    output logic [PRIO_W-1:0]         int_priority,
    output logic [NUM_SRC-1:0]        pending
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] irq_d_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] eligible;
    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [7:0]         vec_q, vec_d;
    logic [PRIO_W-1:0]  prio_q, prio_d;
    logic               req_q, req_d;
    logic               ack_clr;
    logic               win_any;
    logic [IDX_W-1:0]   win_idx;
    logic [PRIO_W-1:0]  win_prio;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_q[i] & ie[i] &
                          (src_prio[i*PRIO_W +: PRIO_W] > cpu_priority);
        end
    end

    lc3_int_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .IDX_W   (IDX_W)
    ) u_prio_sel (
        .eligible_i (eligible),
        .prio_i     (src_prio),
        .any_o      (win_any),
        .idx_o      (win_idx),
        .prio_o     (win_prio)
    );

    // Once latched, vector/priority stay frozen; only eligibility of the latched source can withdraw it.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vec_d   = vec_q;
        prio_d  = prio_q;
        req_d   = req_q;
        ack_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_REQ;
                    sel_d   = win_idx;
                    vec_d   = VEC_BASE + 8'(win_idx);
                    prio_d  = win_prio;
                    req_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    ack_clr = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (!eligible[sel_q]) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A fresh edge wins over an ack clearing the same source in that cycle.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_mode[i]) begin
                pending_d[i] = (irq_in[i] & ~irq_d_q[i]) |
                               (pending_q[i] & ~(ack_clr && (sel_q == IDX_W'(i))));
            end else begin
                pending_d[i] = irq_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        irq_d_q <= irq_in;
        if (rst) begin
            pending_q <= '0;
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            vec_q     <= '0;
            prio_q    <= '0;
            req_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            vec_q     <= vec_d;
            prio_q    <= prio_d;
            req_q     <= req_d;
        end
    end

    assign int_req      = req_q;
    assign int_vector   = vec_q;
    assign int_priority = prio_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Self-checking bench for lc3_int_ctrl: expected requests are queued as stimulus
// is driven and popped by a monitor whenever int_req rises.
module tb_lc3_int_ctrl;

    localparam int NUM_SRC = 8;
    localparam int PRIO_W  = 3;

    typedef struct packed {
        logic [7:0]        vec;
        logic [PRIO_W-1:0] prio;
    } expReq_t;

    logic                      clk;
    logic                      rst;
    logic [NUM_SRC-1:0]        irq_in;
    logic [NUM_SRC-1:0]        edge_mode;
    logic [NUM_SRC-1:0]        ie;
    logic [NUM_SRC*PRIO_W-1:0] src_prio;
    logic [PRIO_W-1:0]         cpu_priority;
    logic                      int_ack;
    logic                      int_req;
    logic [7:0]                int_vector;
    logic [PRIO_W-1:0]         int_priority;
    logic [NUM_SRC-1:0]        pending;

    expReq_t expQ[$];
    int      compareCount  = 0;
    int      mismatchCount = 0;
    logic    prevReq       = 1'b0;

    lc3_int_ctrl #(
        .NUM_SRC  (NUM_SRC),
        .PRIO_W   (PRIO_W),
        .VEC_BASE (8'h80)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .edge_mode    (edge_mode),
        .ie           (ie),
        .src_prio     (src_prio),
        .cpu_priority (cpu_priority),
        .int_ack      (int_ack),
        .int_req      (int_req),
        .int_vector   (int_vector),
        .int_priority (int_priority),
        .pending      (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_SRC-1:0] irq, input logic ack);
        irq_in  = irq;
        int_ack = ack;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every new request must match the oldest queued expectation.
    always @(posedge clk) begin
        #2;
        if (int_req === 1'b1 && prevReq !== 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("sbUnexpectedReq", {24'd0, int_vector}, 32'd0);
            end else begin
                expReq_t e;
                e = expQ.pop_front();
                checkOutput("sbVec", {24'd0, int_vector}, {24'd0, e.vec});
                checkOutput("sbPrio", {29'd0, int_priority}, {29'd0, e.prio});
            end
        end
        prevReq = int_req;
    end

    initial begin
        rst          = 1'b1;
        irq_in       = 8'h01;
        edge_mode    = 8'h01;
        ie           = 8'hFF;
        cpu_priority = 3'd0;
        int_ack      = 1'b0;
        // src7..src0 priorities: 1,7,6,2,4,3,6,5
        src_prio     = {3'd1, 3'd7, 3'd6, 3'd2, 3'd4, 3'd3, 3'd6, 3'd5};

        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h01, 1'b0);
        checkOutput("rstReq", {31'd0, int_req}, 32'd0);
        checkOutput("rstVec", {24'd0, int_vector}, 32'd0);
        checkOutput("rstPrio", {29'd0, int_priority}, 32'd0);
        checkOutput("rstPend", {24'd0, pending}, 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h01, 1'b0);
            checkOutput("relReq", {31'd0, int_req}, 32'd0);
            checkOutput("relPend", {24'd0, pending}, 32'd0);
        end

        edge_mode = 8'h7B;
        applyStimulus(8'h00, 1'b0);

        // Single edge on src 3
        cpu_priority = 3'd2;
        expQ.push_back('{8'h83, 3'd4});
        applyStimulus(8'h08, 1'b0);
        checkOutput("s3Pend", {31'd0, pending[3]}, 32'd1);
        checkOutput("s3ReqEarly", {31'd0, int_req}, 32'd0);
        applyStimulus(8'h08, 1'b0);
        checkOutput("s3Req", {31'd0, int_req}, 32'd1);
        checkOutput("s3Vec", {24'd0, int_vector}, 32'h83);
        checkOutput("s3Prio", {29'd0, int_priority}, 32'd4);
        applyStimulus(8'h08, 1'b1);
        checkOutput("s3AckReq", {31'd0, int_req}, 32'd0);
        checkOutput("s3AckPend", {31'd0, pending[3]}, 32'd0);
        checkOutput("s3HoldVec", {24'd0, int_vector}, 32'h83);
        applyStimulus(8'h00, 1'b0);

        // Tie between src 1 and src 5
        expQ.push_back('{8'h81, 3'd6});
        expQ.push_back('{8'h85, 3'd6});
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h22, 1'b0);
        checkOutput("tieVec1", {24'd0, int_vector}, 32'h81);
        applyStimulus(8'h22, 1'b1);
        checkOutput("tieAckReq", {31'd0, int_req}, 32'd0);
        checkOutput("tiePend", {24'd0, pending}, 32'h20);
        applyStimulus(8'h22, 1'b0);
        checkOutput("tieBubble", {31'd0, int_req}, 32'd0);
        applyStimulus(8'h22, 1'b0);
        checkOutput("tieReq2", {31'd0, int_req}, 32'd1);
        checkOutput("tieVec2", {24'd0, int_vector}, 32'h85);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("tieClear", {24'd0, pending}, 32'd0);

        // Level src 2 withdrawn by raising cpu_priority
        cpu_priority = 3'd0;
        expQ.push_back('{8'h82, 3'd3});
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h04, 1'b0);
        checkOutput("lvlReq", {31'd0, int_req}, 32'd1);
        checkOutput("lvlVec", {24'd0, int_vector}, 32'h82);
        cpu_priority = 3'd3;
        applyStimulus(8'h04, 1'b0);
        checkOutput("lvlWithdraw", {31'd0, int_req}, 32'd0);
        checkOutput("lvlPendKept", {31'd0, pending[2]}, 32'd1);
        applyStimulus(8'h04, 1'b0);
        checkOutput("lvlNoReReq", {31'd0, int_req}, 32'd0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("lvlDrop", {31'd0, pending[2]}, 32'd0);
        cpu_priority = 3'd0;

        // New edge on src 0 coinciding with its ack
        expQ.push_back('{8'h80, 3'd5});
        expQ.push_back('{8'h80, 3'd5});
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h01, 1'b0);
        checkOutput("s0Vec", {24'd0, int_vector}, 32'h80);
        applyStimulus(8'h00, 1'b0);
        checkOutput("s0Held", {31'd0, int_req}, 32'd1);
        applyStimulus(8'h01, 1'b1);
        checkOutput("s0AckReq", {31'd0, int_req}, 32'd0);
        checkOutput("s0SetWins", {31'd0, pending[0]}, 32'd1);
        applyStimulus(8'h01, 1'b0);
        checkOutput("s0Idle", {31'd0, int_req}, 32'd0);
        applyStimulus(8'h01, 1'b0);
        checkOutput("s0ReReq", {31'd0, int_req}, 32'd1);
        applyStimulus(8'h01, 1'b1);
        checkOutput("s0Cleared", {31'd0, pending[0]}, 32'd0);
        applyStimulus(8'h00, 1'b0);

        // Higher-priority src 6 must not preempt latched src 4
        expQ.push_back('{8'h84, 3'd2});
        expQ.push_back('{8'h86, 3'd7});
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h10, 1'b0);
        checkOutput("npVec4", {24'd0, int_vector}, 32'h84);
        applyStimulus(8'h50, 1'b0);
        checkOutput("npPend6", {31'd0, pending[6]}, 32'd1);
        checkOutput("npFrozenVec", {24'd0, int_vector}, 32'h84);
        applyStimulus(8'h50, 1'b0);
        checkOutput("npFrozenPrio", {29'd0, int_priority}, 32'd2);
        checkOutput("npStillReq", {31'd0, int_req}, 32'd1);
        applyStimulus(8'h50, 1'b1);
        checkOutput("npAckReq", {31'd0, int_req}, 32'd0);
        checkOutput("npPend", {24'd0, pending}, 32'h40);
        applyStimulus(8'h50, 1'b0);
        applyStimulus(8'h50, 1'b0);
        checkOutput("npVec6", {24'd0, int_vector}, 32'h86);
        checkOutput("npPrio6", {29'd0, int_priority}, 32'd7);
        applyStimulus(8'h50, 1'b1);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);

        checkOutput("sbEmpty", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
